// File: rtl/perf_counter_bank_pkg.sv
// Shared constants for the performance counter bank: default geometry,
// event channel indices and read-select codes.
package perf_pkg;

    localparam int unsigned PERF_WIDTH_DEF   = 32;
    localparam int unsigned PERF_NUM_EVT_DEF = 4;

    localparam int unsigned EVT_UNCOND  = 0;
    localparam int unsigned EVT_COND    = 1;
    localparam int unsigned EVT_COND_OK = 2;
    localparam int unsigned EVT_MEM     = 3;

    localparam int unsigned RDSEL_CYCLE = 0;

    // Read-select code of event channel ch (cycle counter occupies code 0).
    function automatic int unsigned perf_evt_sel(input int unsigned ch);
        return ch + 1;
    endfunction

endpackage

// File: rtl/perf_ctr_cell.sv
// One counter with a shadow copy; wraps by default, sticks at all-ones when
// PERF_SATURATE_EN is defined.
module perf_ctr_cell #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             snap,
    output logic [WIDTH-1:0] live,
    output logic [WIDTH-1:0] shadow
);

    logic [WIDTH-1:0] r_live;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_live + WIDTH'(1);
`ifdef PERF_SATURATE_EN
        if (r_live == '1) begin
            w_next = r_live;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live   <= '0;
            r_shadow <= '0;
        end else begin
            // Shadow takes the value from before this edge's clear/increment.
            if (snap) begin
                r_shadow <= r_live;
            end
            if (clr) begin
                r_live <= '0;
            end else if (inc) begin
                r_live <= w_next;
            end
        end
    end

    assign live   = r_live;
    assign shadow = r_shadow;

endmodule

// File: rtl/perf_counter_bank.sv
// Halt-aware cycle counter plus NUM_EVT event counters with freeze, clear,
// snapshot and a registered read port. Optional feature macro: PERF_SATURATE_EN.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned WIDTH   = PERF_WIDTH_DEF,
    parameter int unsigned NUM_EVT = PERF_NUM_EVT_DEF,
    parameter int unsigned SEL_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic [NUM_EVT-1:0] event_vec,
    input  logic               freeze,
    input  logic               clr,
    input  logic               snap,
    input  logic               rd_shadow,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [WIDTH-1:0]   rd_data,
    output logic [WIDTH-1:0]   cycle_cnt,
    output logic               halted
);

    logic               r_halted;
    logic [WIDTH-1:0]   r_rd_data;
    logic               w_cnt_en;
    logic [NUM_EVT:0]   w_inc;
    logic [WIDTH-1:0]   w_live   [NUM_EVT+1];
    logic [WIDTH-1:0]   w_shadow [NUM_EVT+1];
    logic [WIDTH-1:0]   w_rd_mux;

    // The halt-entry cycle still counts; later halted cycles do not.
    assign w_cnt_en = !freeze && (!halt || !r_halted);
    assign w_inc    = {event_vec & {NUM_EVT{w_cnt_en}}, w_cnt_en};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (clr) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= halt;
        end
    end

    for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cell
        perf_ctr_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .inc    (w_inc[g]),
            .snap   (snap),
            .live   (w_live[g]),
            .shadow (w_shadow[g])
        );
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int unsigned i = 0; i <= NUM_EVT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                w_rd_mux = rd_shadow ? w_shadow[i] : w_live[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data   = r_rd_data;
    assign cycle_cnt = w_live[RDSEL_CYCLE];
    assign halted    = r_halted;

endmodule
